// File: rtl/seq_pkg.sv
// Shared constants and sizing helpers for the time-multiplexed pattern detector.
package seq_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int ch_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  localparam int DEF_NCH  = 4;
  localparam int DEF_PLEN = 4;
  localparam logic [DEF_PLEN-1:0] DEF_PAT = 4'b1101;
  localparam int CH_W = (DEF_NCH > 1) ? clog2(DEF_NCH) : 1;

endpackage

// File: rtl/seq_sched_if.sv
// Request/grant and result bundle between the serial front-ends, the scheduler and the logger.
interface seq_sched_if import seq_pkg::*; #(
  parameter int NCH = DEF_NCH
) ();
  localparam int CW = ch_w(NCH);

  logic           en;
  logic [NCH-1:0] req_vld;
  logic [NCH-1:0] req_bit;
  logic [NCH-1:0] req_rdy;
  logic [NCH-1:0] clr;
  logic           res_vld;
  logic [CW-1:0]  res_ch;
  logic           res_hit;

  modport master (
    output en, req_vld, req_bit, clr,
    input  req_rdy, res_vld, res_ch, res_hit
  );

  modport slave (
    input  en, req_vld, req_bit, clr,
    output req_rdy, res_vld, res_ch, res_hit
  );
endinterface

// File: rtl/seq_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module seq_rr_arb import seq_pkg::*; #(
  parameter  int NCH = DEF_NCH,
  localparam int CW  = ch_w(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic           en_i,
  input  logic [CW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [CW-1:0]  gnt_id_o,
  output logic           any_o
);

  logic [CW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = '0;
    if (en_i) begin
      for (int k = 0; k < NCH; k++) begin
        idx = CW'((int'(ptr_i) + k) % NCH);
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          gnt_id_o   = idx;
        end
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/seq_sched.sv
// One shared shift/compare datapath serving NCH serial streams, with per-channel saved context.
module seq_sched import seq_pkg::*; #(
  parameter int              NCH  = DEF_NCH,
  parameter int              PLEN = DEF_PLEN,
  parameter logic [PLEN-1:0] PAT  = DEF_PAT
) (
  input logic        clk,
  input logic        rst,
  seq_sched_if.slave bus
);

  localparam int CW = ch_w(NCH);
  localparam int FW = clog2(PLEN + 1);

  logic [CW-1:0]                ptr_q, ptr_d;
  logic [NCH-1:0][PLEN-1:0]     hist_q, hist_d;
  logic [NCH-1:0][FW-1:0]       fill_q, fill_d;
  logic                         res_vld_q, res_vld_d;
  logic                         res_hit_q, res_hit_d;
  logic [CW-1:0]                res_ch_q, res_ch_d;

  logic [NCH-1:0] gnt;
  logic [CW-1:0]  gnt_id;
  logic           any;
  logic [PLEN-1:0] base_h, h_new;
  logic [FW-1:0]   base_f, f_new;
  logic            hit;

  seq_rr_arb #(.NCH(NCH)) u_arb (
    .req_i    (bus.req_vld),
    .en_i     (bus.en & ~rst),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (any)
  );

  assign bus.req_rdy = gnt;

  // A clear on the granted channel wipes its context before the new bit shifts in.
  always_comb begin
    base_h = bus.clr[gnt_id] ? '0 : hist_q[gnt_id];
    base_f = bus.clr[gnt_id] ? '0 : fill_q[gnt_id];
    h_new  = {base_h[PLEN-2:0], bus.req_bit[gnt_id]};
    f_new  = (base_f == FW'(PLEN)) ? base_f : base_f + 1'b1;
    hit    = any && (f_new == FW'(PLEN)) && (h_new == PAT);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    for (int i = 0; i < NCH; i++) begin
      if (any && (gnt_id == CW'(i))) begin
        hist_d[i] = h_new;
        fill_d[i] = f_new;
      end else if (bus.clr[i]) begin
        hist_d[i] = '0;
        fill_d[i] = '0;
      end
    end
    ptr_d = ptr_q;
    if (any) ptr_d = (gnt_id == CW'(NCH - 1)) ? '0 : gnt_id + 1'b1;
    res_vld_d = any;
    res_hit_d = hit;
    res_ch_d  = any ? gnt_id : res_ch_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      res_vld_q <= 1'b0;
      res_hit_q <= 1'b0;
      res_ch_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      res_vld_q <= res_vld_d;
      res_hit_q <= res_hit_d;
      res_ch_q  <= res_ch_d;
    end
  end

  assign bus.res_vld = res_vld_q;
  assign bus.res_hit = res_hit_q;
  assign bus.res_ch  = res_ch_q;

endmodule
